bomb_field: RTL and testbench
=============================

BOMB_FIELD -- requirements
Module: bomb_field

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of grid rows (2..16).
REQ-002 SHALL have parameter COLS, default 16, number of grid columns (2..16).
REQ-003 SHALL have port clock  in  1  single clock; every register updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports mv_right, mv_left, mv_down, mv_up  in  1 each  single-cycle cursor move pulses (already debounced).
REQ-006 SHALL have ports reveal, flag_tog  in  1 each  single-cycle command pulses.
REQ-007 SHALL have ports mine_load  in  1 (load strobe) and mine_map  in  ROWS*COLS (cell (r,c) at bit r*COLS+c).
REQ-008 SHALL have ports scan_tick  in  1 (display row-advance pulse) and tick_1s  in  1 (one-second pulse).
REQ-009 SHALL have ports cur_row  out  clog2(ROWS) and cur_col  out  clog2(COLS), the cursor position.
REQ-010 SHALL have ports dot_row  out  ROWS (active-low one-hot row select) and dot_col  out  COLS (active-high column data).
REQ-011 SHALL have ports game_state  out  2 (0 IDLE, 1 PLAY, 2 LOST, 3 WON), nbr_cnt  out  4, and elapsed_s  out  16.

Function
REQ-012 SHALL implement FSM IDLE -> PLAY on mine_load; PLAY -> LOST when an unflagged mined cell is revealed; PLAY -> WON when revealed count equals ROWS*COLS minus mine count; any state -> PLAY on mine_load.
REQ-013 On mine_load SHALL latch mine_map, register its popcount, clear all revealed/flagged bits, set the cursor to (0,0), and zero elapsed_s, all in one cycle.
REQ-014 In PLAY, reveal SHALL set the cursor cell's revealed bit unless the cell is flagged or already revealed (no-op in both cases, count unchanged).
REQ-015 In PLAY, flag_tog SHALL invert the cursor cell's flagged bit unless the cell is revealed (no-op).
REQ-016 Moves SHALL clamp at grid edges with no wrap; opposing pulses in the same cycle cancel; one horizontal and one vertical pulse in the same cycle both apply.
REQ-017 Command priority in a single cycle SHALL be mine_load > reveal > flag_tog; moves SHALL take effect after the command, so a command acts on the pre-move cursor.
REQ-018 Win check SHALL be evaluated every PLAY cycle, so the WON transition occurs one cycle after the qualifying reveal (including a load with zero safe cells).
REQ-019 In IDLE, LOST and WON, reveal, flag_tog and moves SHALL be ignored.
REQ-020 nbr_cnt SHALL hold the count of mines among the up-to-8 in-grid neighbours of the cursor, registered, valid one cycle after any cursor or map change.
REQ-021 Display: the scan row index SHALL advance on scan_tick and wrap from ROWS-1 to 0; dot_row bit r low for the scanned row r; dot_col[c] = revealed|flagged of (r,c), ORed with mine bits when in LOST; both outputs registered, one cycle after the index changes.

Reset
REQ-022 reset SHALL force IDLE, mine_map, revealed and flagged bits to 0, cursor to (0,0), scan row to 0, dot_row all ones except bit 0 low, dot_col 0, nbr_cnt 0, and elapsed_s 0.
REQ-023 reset SHALL override every input in the same cycle, including a mid-game or simultaneous mine_load.

Configuration
REQ-024 With macro BOMB_TIMER_EN defined, elapsed_s SHALL increment on tick_1s only in PLAY, hold in LOST/WON/IDLE, and saturate at 65535.
REQ-025 Without BOMB_TIMER_EN, elapsed_s SHALL be constant 0 and tick_1s ignored; ports remain present.

Verification
REQ-026 Load mine_map with only bit 17 set (8x16), move down 1 and right 1, reveal -> LOST next cycle, dot_col for row 1 = 0x0002.
REQ-027 Load a single mine at bit 0, reveal all other 127 cells -> game_state WON one cycle after the last reveal; further reveals ignored.
REQ-028 Cursor at (0,0); pulse mv_left and mv_up -> stays (0,0); pulse mv_right and mv_left together -> stays (0,0); 20 mv_right pulses -> cur_col 15.
REQ-029 flag_tog then reveal on a mined cell -> state stays PLAY, revealed count 0; flag_tog again then reveal -> LOST.
REQ-030 Mines at (0,1),(1,0),(1,1), cursor (0,0) -> nbr_cnt 3 one cycle after load; move right -> nbr_cnt 2.
REQ-031 With BOMB_TIMER_EN defined, 5 tick_1s in PLAY -> elapsed_s 5; enter LOST, 3 more ticks -> 5; reset during PLAY -> IDLE, elapsed_s 0.

Source files
------------

// File: rtl/bomb_field.sv
// Minesweeper-style playfield: cursor, reveal/flag state, neighbour count and LED-matrix scan.
// Optional play timer is enabled with macro BOMB_TIMER_EN; otherwise elapsed_s is tied to 0.
module bomb_field #(
    parameter int ROWS = 8,
    parameter int COLS = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mv_right,
    input  logic                     mv_left,
    input  logic                     mv_down,
    input  logic                     mv_up,
    input  logic                     reveal,
    input  logic                     flag_tog,
    input  logic                     mine_load,
    input  logic [ROWS*COLS-1:0]     mine_map,
    input  logic                     scan_tick,
    input  logic                     tick_1s,
    output logic [$clog2(ROWS)-1:0]  cur_row,
    output logic [$clog2(COLS)-1:0]  cur_col,
    output logic [ROWS-1:0]          dot_row,
    output logic [COLS-1:0]          dot_col,
    output logic [1:0]               game_state,
    output logic [3:0]               nbr_cnt,
    output logic [15:0]              elapsed_s
);
    localparam int CELLS = ROWS * COLS;
    localparam int RW    = $clog2(ROWS);
    localparam int CLW   = $clog2(COLS);
    localparam int IW    = $clog2(CELLS);
    localparam int CW    = $clog2(CELLS + 1);
    localparam logic [RW-1:0]  ROW_MAX = RW'(ROWS - 1);
    localparam logic [CLW-1:0] COL_MAX = CLW'(COLS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, LOST = 2'd2, WON = 2'd3} state_t;

    state_t             state;
    logic [CELLS-1:0]   mines, revealed, flagged, visible;
    logic [CW-1:0]      mine_cnt, rev_cnt;
    logic [RW-1:0]      scan_row, row_next;
    logic [CLW-1:0]     col_next;
    logic [IW-1:0]      cur_idx, scan_base;
    logic [3:0]         nbr_next;

    assign game_state = state;
    assign cur_idx    = IW'(int'(cur_row) * COLS + int'(cur_col));
    assign scan_base  = IW'(int'(scan_row) * COLS);
    assign visible    = revealed | flagged | ((state == LOST) ? mines : '0);

    function automatic logic mine_at(input logic [CELLS-1:0] m, input int r, input int c);
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
        return m[IW'(r * COLS + c)];
    endfunction

    always_comb begin
        nbr_next = '0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0)
                    nbr_next = nbr_next + 4'(mine_at(mines, int'(cur_row) + dr, int'(cur_col) + dc));
    end

    // Opposing pulses cancel; edges clamp rather than wrap.
    always_comb begin
        row_next = cur_row;
        col_next = cur_col;
        if (mv_down && !mv_up && cur_row != ROW_MAX)
            row_next = cur_row + RW'(1);
        else if (mv_up && !mv_down && cur_row != '0)
            row_next = cur_row - RW'(1);
        if (mv_right && !mv_left && cur_col != COL_MAX)
            col_next = cur_col + CLW'(1);
        else if (mv_left && !mv_right && cur_col != '0)
            col_next = cur_col - CLW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            mines    <= '0;
            revealed <= '0;
            flagged  <= '0;
            mine_cnt <= '0;
            rev_cnt  <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
        end else if (mine_load) begin
            state    <= PLAY;
            mines    <= mine_map;
            mine_cnt <= CW'($countones(mine_map));
            revealed <= '0;
            flagged  <= '0;
            rev_cnt  <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
        end else if (state == PLAY) begin
            // Commands act on the pre-move cursor; the move lands in the same cycle.
            if (reveal) begin
                if (!flagged[cur_idx] && !revealed[cur_idx]) begin
                    revealed[cur_idx] <= 1'b1;
                    rev_cnt           <= rev_cnt + CW'(1);
                    if (mines[cur_idx]) state <= LOST;
                end
            end else if (flag_tog) begin
                if (!revealed[cur_idx]) flagged[cur_idx] <= !flagged[cur_idx];
            end
            cur_row <= row_next;
            cur_col <= col_next;
            // Win check looks at last cycle's count, so WON lands one cycle after the final reveal.
            if (rev_cnt == CW'(CELLS) - mine_cnt) state <= WON;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_row <= '0;
            dot_row  <= ~ROWS'(1);
            dot_col  <= '0;
            nbr_cnt  <= '0;
        end else begin
            if (scan_tick) scan_row <= (scan_row == ROW_MAX) ? '0 : scan_row + RW'(1);
            dot_row <= ~(ROWS'(1) << scan_row);
            dot_col <= visible[scan_base +: COLS];
            nbr_cnt <= nbr_next;
        end
    end

`ifdef BOMB_TIMER_EN
    always_ff @(posedge clock) begin
        if (reset || mine_load)
            elapsed_s <= '0;
        else if (state == PLAY && tick_1s && elapsed_s != 16'hFFFF)
            elapsed_s <= elapsed_s + 16'd1;
    end
`else
    logic unused_tick;
    assign unused_tick = tick_1s;
    assign elapsed_s   = 16'd0;
`endif

endmodule

// File: tb/tb_bomb_field.sv
// Bench for bomb_field (8x16): vector table for cursor/neighbour/display, plus game sequences.
module tb_bomb_field;
    logic         clock = 1'b0;
    logic         reset, mv_right, mv_left, mv_down, mv_up, reveal, flag_tog;
    logic         mine_load, scan_tick, tick_1s;
    logic [127:0] mine_map;
    logic [2:0]   cur_row;
    logic [3:0]   cur_col;
    logic [7:0]   dot_row;
    logic [15:0]  dot_col;
    logic [1:0]   game_state;
    logic [3:0]   nbr_cnt;
    logic [15:0]  elapsed_s;

    bomb_field #(.ROWS(8), .COLS(16)) dut (
        .clock(clock), .reset(reset),
        .mv_right(mv_right), .mv_left(mv_left), .mv_down(mv_down), .mv_up(mv_up),
        .reveal(reveal), .flag_tog(flag_tog), .mine_load(mine_load), .mine_map(mine_map),
        .scan_tick(scan_tick), .tick_1s(tick_1s),
        .cur_row(cur_row), .cur_col(cur_col), .dot_row(dot_row), .dot_col(dot_col),
        .game_state(game_state), .nbr_cnt(nbr_cnt), .elapsed_s(elapsed_s)
    );

    always #5 clock = ~clock;

`ifdef BOMB_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif

    typedef struct { string name; logic [31:0] want; } exp_t;
    typedef struct { logic [5:0] ctrl; int row; int col; int st; int nbr; int dcol; } vec_t;

    exp_t sbq[$];
    vec_t vt[17];
    int   checks = 0;
    int   errors = 0;
    int   c;
    logic [5:0] ctl;

    // ctrl bit order: {right, left, down, up, reveal, flag_tog}
    localparam logic [5:0] R = 6'b100000, L = 6'b010000, D = 6'b001000, U = 6'b000100,
                           RV = 6'b000010, FL = 6'b000001;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [5:0] ctrl);
        {mv_right, mv_left, mv_down, mv_up, reveal, flag_tog} = ctrl;
        cyc();
        {mv_right, mv_left, mv_down, mv_up, reveal, flag_tog} = 6'b0;
    endtask

    task automatic load(input logic [127:0] m);
        mine_map  = m;
        mine_load = 1'b1;
        cyc();
        mine_load = 1'b0;
    endtask

    task automatic pulse_tick1s(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1s = 1'b1;
            cyc();
            tick_1s = 1'b0;
            cyc();
        end
    endtask

    task automatic expect_v(input string name, input logic [31:0] want);
        exp_t e;
        e.name = name;
        e.want = want;
        sbq.push_back(e);
    endtask

    task automatic cmp(input logic [31:0] got);
        exp_t e;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got %0h", got);
            return;
        end
        e = sbq.pop_front();
        checks++;
        if (got !== e.want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", e.name, got, e.want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{L | U,   0, 0, 1, 3, 'h0};
        vt[1]  = '{R | L,   0, 0, 1, 3, 'h0};
        vt[2]  = '{R,       0, 1, 1, 2, 'h0};
        vt[3]  = '{R,       0, 2, 1, 2, 'h0};
        vt[4]  = '{D | R,   1, 3, 1, 0, 'h0};
        vt[5]  = '{D | U,   1, 3, 1, 0, 'h0};
        vt[6]  = '{L,       1, 2, 1, 2, 'h0};
        vt[7]  = '{RV | L,  1, 1, 1, 2, 'h4};
        vt[8]  = '{FL | D,  2, 1, 1, 2, 'h6};
        vt[9]  = '{U,       1, 1, 1, 2, 'h6};
        vt[10] = '{RV,      1, 1, 1, 2, 'h6};
        vt[11] = '{R,       1, 2, 1, 2, 'h6};
        vt[12] = '{FL,      1, 2, 1, 2, 'h6};
        vt[13] = '{L,       1, 1, 1, 2, 'h6};
        vt[14] = '{FL,      1, 1, 1, 2, 'h4};
        vt[15] = '{RV,      1, 1, 2, 2, 'h7};
        vt[16] = '{R,       1, 1, 2, 2, 'h7};

        {mv_right, mv_left, mv_down, mv_up, reveal, flag_tog} = 6'b0;
        mine_load = 1'b0; scan_tick = 1'b0; tick_1s = 1'b0; mine_map = '0;
        reset = 1'b1;
        cyc();
        expect_v("rst_state", 0); expect_v("rst_row", 0); expect_v("rst_col", 0);
        expect_v("rst_dot_row", 8'hFE); expect_v("rst_dot_col", 0);
        expect_v("rst_nbr", 0); expect_v("rst_elapsed", 0);
        cyc();
        cmp(game_state); cmp(cur_row); cmp(cur_col); cmp(dot_row); cmp(dot_col);
        cmp(nbr_cnt); cmp(elapsed_s);
        reset = 1'b0;

        // IDLE ignores moves and commands
        expect_v("idle_state", 0); expect_v("idle_row", 0); expect_v("idle_col", 0);
        drive(R | D | RV);
        cmp(game_state); cmp(cur_row); cmp(cur_col);

        // Display on row 1, then mines at (0,1),(1,0),(1,1)
        scan_tick = 1'b1; cyc(); scan_tick = 1'b0;
        expect_v("load_state", 1); expect_v("load_nbr", 3); expect_v("load_dot_row", 8'hFD);
        load(128'h3_0002);
        cyc();
        cmp(game_state); cmp(nbr_cnt); cmp(dot_row);

        for (int i = 0; i < 17; i++) begin
            expect_v($sformatf("vec%0d_row", i), vt[i].row);
            expect_v($sformatf("vec%0d_col", i), vt[i].col);
            expect_v($sformatf("vec%0d_state", i), vt[i].st);
            expect_v($sformatf("vec%0d_nbr", i), vt[i].nbr);
            expect_v($sformatf("vec%0d_dot_col", i), vt[i].dcol);
            drive(vt[i].ctrl);
            cyc();
            cmp(cur_row); cmp(cur_col); cmp(game_state); cmp(nbr_cnt); cmp(dot_col);
        end

        // Scan wraps 1 -> 0 after 7 ticks; LOST shows the mine at (0,1)
        expect_v("wrap_dot_row", 8'hFE); expect_v("wrap_dot_col", 16'h0002);
        scan_tick = 1'b1; repeat (7) cyc(); scan_tick = 1'b0;
        cyc();
        cmp(dot_row); cmp(dot_col);

        // Reset wins over a simultaneous load
        expect_v("rstld_state", 0); expect_v("rstld_dot_col", 0); expect_v("rstld_nbr", 0);
        mine_map = 128'h2_0000; reset = 1'b1; mine_load = 1'b1;
        cyc();
        reset = 1'b0; mine_load = 1'b0;
        cyc();
        cmp(game_state); cmp(dot_col); cmp(nbr_cnt);

        // Single mine at (1,1): diagonal move then reveal loses
        load(128'h2_0000);
        expect_v("b17_row", 1); expect_v("b17_col", 1);
        drive(D | R);
        cmp(cur_row); cmp(cur_col);
        expect_v("b17_lost", 2);
        drive(RV);
        cmp(game_state);
        expect_v("b17_dot_row", 8'hFD); expect_v("b17_dot_col", 16'h0002);
        scan_tick = 1'b1; cyc(); scan_tick = 1'b0;
        cyc();
        cmp(dot_row); cmp(dot_col);

        // Reload from LOST, then load beats a same-cycle reveal of the mined cursor cell
        expect_v("reload_state", 1); expect_v("reload_row", 0); expect_v("reload_col", 0);
        load(128'h1);
        cmp(game_state); cmp(cur_row); cmp(cur_col);
        expect_v("prio_state", 1);
        mine_map = 128'h1; mine_load = 1'b1; reveal = 1'b1;
        cyc();
        mine_load = 1'b0; reveal = 1'b0;
        cyc();
        cmp(game_state);

        // Flagged mine cannot be revealed; unflagged can
        drive(FL);
        expect_v("flag_protect", 1);
        drive(RV);
        cyc();
        cmp(game_state);
        drive(FL);
        expect_v("unflag_lost", 2);
        drive(RV);
        cmp(game_state);

        // Timer
        reset = 1'b1; cyc(); reset = 1'b0;
        load(128'h1);
        expect_v("tmr_play5", TMR ? 5 : 0);
        pulse_tick1s(5);
        cmp(elapsed_s);
        drive(RV);
        expect_v("tmr_lost_hold", TMR ? 5 : 0);
        pulse_tick1s(3);
        cmp(elapsed_s);
        expect_v("tmr_load_clear", 0);
        load(128'h1);
        cmp(elapsed_s);
        pulse_tick1s(2);
        expect_v("tmr_rst_state", 0); expect_v("tmr_rst_elapsed", 0);
        reset = 1'b1; cyc(); reset = 1'b0;
        cmp(game_state); cmp(elapsed_s);

        // All cells mined: no safe cells, WON one cycle after load
        expect_v("allmine_play", 1);
        load({128{1'b1}});
        cmp(game_state);
        expect_v("allmine_won", 3);
        cyc();
        cmp(game_state);

        // Mine at (0,0); snake-reveal the other 127 cells
        load(128'h1);
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 16; k++) begin
                c   = (r % 2 == 0) ? k : 15 - k;
                ctl = 6'b0;
                if (!(r == 0 && c == 0)) ctl = ctl | RV;
                if (k < 15) ctl = ctl | ((r % 2 == 0) ? R : L);
                else if (r < 7) ctl = ctl | D;
                drive(ctl);
            end
        expect_v("win_pending", 1); expect_v("win_row", 7); expect_v("win_col", 0);
        cmp(game_state); cmp(cur_row); cmp(cur_col);
        expect_v("win_state", 3);
        cyc();
        cmp(game_state);
        expect_v("won_hold", 3); expect_v("won_row", 7);
        drive(RV | U);
        cmp(game_state); cmp(cur_row);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
